// File: rtl/dpram_frame_reader.sv
// Read-side master for a 1R/1W block SRAM: streams one frame from the read port onto a
// valid/ready stream in natural or bit-reversed address order, absorbing the 1-cycle read latency.
module dpram_frame_reader #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] len_m1,
    input  logic                  bitrev,
    output logic                  busy,
    output logic                  done,
    output logic                  ract,
    output logic [ADDR_WIDTH-1:0] ra,
    input  logic [DATA_WIDTH-1:0] rdr,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] len_q;
    logic                  bitrev_q;
    logic                  vld_p1;
    logic                  last_p1;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_last;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_cnt;
    logic                  pop;
    logic                  issue_last;

    function automatic logic [ADDR_WIDTH-1:0] bit_reverse(input logic [ADDR_WIDTH-1:0] v);
        logic [ADDR_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_WIDTH; i++) r[i] = v[ADDR_WIDTH-1-i];
        return r;
    endfunction

    assign busy       = (state != IDLE);
    assign m_valid    = (fifo_cnt != 2'd0);
    assign pop        = m_valid & m_ready;
    // Credit rule: queued words plus the read in flight never exceed the two FIFO slots.
    assign ract       = (state == RUN) && (((fifo_cnt + {1'b0, vld_p1}) < 2'd2) || pop);
    assign issue_last = ract && (cnt == len_q);
    assign ra         = bitrev_q ? bit_reverse(cnt) : cnt;
    assign m_data     = fifo_data[rd_ptr];
    assign m_last     = m_valid & fifo_last[rd_ptr];

    // Stage p0: read issue and frame control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            len_q    <= '0;
            bitrev_q <= 1'b0;
            done     <= 1'b0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
        end else begin
            done    <= 1'b0;
            vld_p1  <= ract;
            last_p1 <= issue_last;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        cnt      <= '0;
                        len_q    <= len_m1;
                        bitrev_q <= bitrev;
                    end
                end
                RUN: begin
                    if (ract) begin
                        if (cnt == len_q) state <= DRAIN;
                        else              cnt   <= cnt + CNT_ONE;
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1: returned RAM word lands in the skid FIFO; storage is cleared so m_data reads 0 out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_cnt     <= 2'd0;
        end else begin
            if (vld_p1) begin
                fifo_data[wr_ptr] <= rdr;
                fifo_last[wr_ptr] <= last_p1;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, vld_p1} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_dpram_frame_reader.sv
// Bench for dpram_frame_reader: behavioural SRAM, scoreboard of expected beats, scenario tasks.
module tb_dpram_frame_reader;
    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n, start, bitrev, m_ready;
    logic [AW-1:0] len_m1, ra;
    logic          busy, done, ract, m_valid, m_last;
    logic [DW-1:0] rdr, m_data;
    logic [DW-1:0] mem [2**AW];

    logic          start3;
    logic [2:0]    len3 = 3'd7;
    logic          bitrev3 = 1'b1;
    logic          m_ready3 = 1'b1;
    logic          busy3, done3, ract3, m_valid3, m_last3;
    logic [2:0]    ra3;
    logic [DW-1:0] rdr3, m_data3;
    logic [DW-1:0] mem3 [8];

    always #5 clk = ~clk;

    dpram_frame_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len_m1(len_m1), .bitrev(bitrev),
        .busy(busy), .done(done), .ract(ract), .ra(ra), .rdr(rdr),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last));

    dpram_frame_reader #(.ADDR_WIDTH(3), .DATA_WIDTH(DW)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .len_m1(len3), .bitrev(bitrev3),
        .busy(busy3), .done(done3), .ract(ract3), .ra(ra3), .rdr(rdr3),
        .m_valid(m_valid3), .m_ready(m_ready3), .m_data(m_data3), .m_last(m_last3));

    always @(posedge clk) if (ract) rdr <= mem[ra];
    always @(posedge clk) if (ract3) rdr3 <= mem3[ra3];

    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int r_first_pop, r_last_pop, r_done_k, r_done_cnt, r_ract_cnt, r_busy_cnt;

    function automatic logic [AW-1:0] rev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
        return r;
    endfunction

    // Drives one frame and checks every beat against the scoreboard plus an occupancy model.
    task automatic run_frame(input string name, input int len, input bit br, input int rdy_pct,
                             input bit pre, input int junk_k, input int abort_pops,
                             input bit chain, input int next_len, input bit next_br);
        int pushed = 0, pops = 0, occ;
        bit r1 = 0, r2 = 0, hold = 0;
        logic [DW-1:0] hold_data;
        logic hold_last;
        logic [AW-1:0] a;
        beat_t b;
        for (int i = 0; i <= len; i++) begin
            a = AW'(i);
            b.data = mem[br ? rev(a) : a];
            b.last = (i == len);
            exp_q.push_back(b);
        end
        r_first_pop = -1; r_last_pop = -1; r_done_k = -1;
        r_done_cnt = 0; r_ract_cnt = 0; r_busy_cnt = 0;
        if (!pre) begin
            @(negedge clk);
            len_m1 = AW'(len); bitrev = br; start = 1'b1;
        end
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            start = (k == junk_k);
            if (k == junk_k) begin len_m1 = ~len_m1; bitrev = ~bitrev; end
            m_ready = ($urandom_range(99) < rdy_pct);
            #1;
            if (r2) pushed++;
            occ = pushed - pops;
            checks++;
            if (occ > 2 || m_valid !== (occ != 0)) begin
                errors++;
                $display("FAIL %s occupancy k=%0d m_valid=%b model_occ=%0d", name, k, m_valid, occ);
            end
            if (hold) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== hold_data || m_last !== hold_last) begin
                    errors++;
                    $display("FAIL %s hold k=%0d got v=%b d=%0h l=%b exp v=1 d=%0h l=%b",
                             name, k, m_valid, m_data, m_last, hold_data, hold_last);
                end
            end
            if (ract) r_ract_cnt++;
            if (busy) r_busy_cnt++;
            if (done) begin
                r_done_cnt++;
                if (r_done_k < 0) r_done_k = k;
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra beat got %0h exp none", name, m_data);
                end else begin
                    b = exp_q.pop_front();
                    if (m_data !== b.data || m_last !== b.last) begin
                        errors++;
                        $display("FAIL %s beat k=%0d got d=%0h l=%b exp d=%0h l=%b",
                                 name, k, m_data, m_last, b.data, b.last);
                    end
                end
                if (r_first_pop < 0) r_first_pop = k;
                r_last_pop = k;
                pops++;
            end
            hold = m_valid && !m_ready; hold_data = m_data; hold_last = m_last;
            r2 = r1; r1 = ract;
            if (abort_pops > 0 && pops == abort_pops) return;
            if (chain && done) begin
                start = 1'b1; len_m1 = AW'(next_len); bitrev = next_br;
                return;
            end
            if (r_done_k > 0 && k >= r_done_k + 2) return;
        end
        checks++; errors++;
        $display("FAIL %s timeout got no done exp done within 400 cycles", name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len_m1 = '0; bitrev = 1'b0; m_ready = 1'b0; start3 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, ract, ra, m_valid, m_last, m_data} !== '0) begin
            errors++;
            $display("FAIL reset got busy=%b done=%b ract=%b ra=%0h v=%b l=%b d=%0h exp all 0",
                     busy, done, ract, ra, m_valid, m_last, m_data);
        end
        checks++;
        if ({busy3, ract3, m_valid3} !== 3'b000) begin
            errors++;
            $display("FAIL reset3 got %b exp 000", {busy3, ract3, m_valid3});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_natural();
        run_frame("natural", 7, 0, 100, 0, 0, 0, 0, 0, 0);
        checks++; if (r_first_pop !== 3) begin errors++; $display("FAIL nat_latency got %0d exp 3", r_first_pop); end
        checks++; if (r_last_pop !== 10) begin errors++; $display("FAIL nat_last_pop got %0d exp 10", r_last_pop); end
        checks++; if (r_ract_cnt !== 8) begin errors++; $display("FAIL nat_ract got %0d exp 8", r_ract_cnt); end
        checks++; if (r_done_k !== 11) begin errors++; $display("FAIL nat_done_k got %0d exp 11", r_done_k); end
        checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL nat_done_cnt got %0d exp 1", r_done_cnt); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL nat_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_bitrev_full();
        run_frame("bitrev_full", 2**AW-1, 1, 100, 0, 0, 0, 0, 0, 0);
        checks++; if (r_ract_cnt !== 16) begin errors++; $display("FAIL brf_ract got %0d exp 16", r_ract_cnt); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL brf_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_bitrev_aw3();
        int exp3[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
        int n = 0;
        int dn = 0;
        @(negedge clk); start3 = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk); start3 = 1'b0; #1;
            if (m_valid3) begin
                checks++;
                if (n >= 8) begin
                    errors++; $display("FAIL aw3 extra got %0h exp none", m_data3);
                end else if (m_data3 !== DW'(exp3[n]) || m_last3 !== (n == 7)) begin
                    errors++;
                    $display("FAIL aw3 beat %0d got d=%0h l=%b exp d=%0h l=%b", n, m_data3, m_last3, exp3[n], n == 7);
                end
                n++;
            end
            if (done3) dn++;
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL aw3_count got %0d exp 8", n); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL aw3_done got %0d exp 1", dn); end
    endtask

    task automatic test_random_ready();
        run_frame("random_ready", 15, 0, 50, 0, 0, 0, 0, 0, 0);
        checks++; if (r_ract_cnt !== 16) begin errors++; $display("FAIL rr_ract got %0d exp 16", r_ract_cnt); end
        checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL rr_done got %0d exp 1", r_done_cnt); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rr_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_single();
        run_frame("single", 0, 0, 100, 0, 0, 0, 0, 0, 0);
        checks++; if (r_busy_cnt !== 3) begin errors++; $display("FAIL single_busy got %0d exp 3", r_busy_cnt); end
        checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL single_done got %0d exp 1", r_done_cnt); end
        checks++; if (r_done_k !== 4) begin errors++; $display("FAIL single_done_k got %0d exp 4", r_done_k); end
        checks++; if (r_ract_cnt !== 1) begin errors++; $display("FAIL single_ract got %0d exp 1", r_ract_cnt); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL single_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        run_frame("abort", 15, 0, 100, 0, 0, 5, 0, 0, 0);
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        checks++;
        if ({busy, done, ract, ra, m_valid, m_last, m_data} !== '0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b done=%b ract=%b ra=%0h v=%b l=%b d=%0h exp all 0",
                     busy, done, ract, ra, m_valid, m_last, m_data);
        end
        exp_q.delete();
        @(negedge clk); rst_n = 1'b1;
        run_frame("after_reset", 15, 0, 100, 0, 0, 0, 0, 0, 0);
        checks++; if (r_first_pop !== 3) begin errors++; $display("FAIL ar_latency got %0d exp 3", r_first_pop); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL ar_left got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_a", 3, 0, 100, 0, 2, 0, 1, 5, 1);
        checks++; if (r_ract_cnt !== 4) begin errors++; $display("FAIL b2b_a_ract got %0d exp 4", r_ract_cnt); end
        checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL b2b_a_done got %0d exp 1", r_done_cnt); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_a_left got %0d exp 0", exp_q.size()); end
        run_frame("b2b_b", 5, 1, 100, 1, 0, 0, 0, 0, 0);
        checks++; if (r_first_pop !== 3) begin errors++; $display("FAIL b2b_b_latency got %0d exp 3", r_first_pop); end
        checks++; if (r_ract_cnt !== 6) begin errors++; $display("FAIL b2b_b_ract got %0d exp 6", r_ract_cnt); end
        checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL b2b_b_done got %0d exp 1", r_done_cnt); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_b_left got %0d exp 0", exp_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i);
        for (int i = 0; i < 8; i++) mem3[i] = DW'(i);
        test_reset();
        test_natural();
        test_bitrev_full();
        test_bitrev_aw3();
        test_random_ready();
        test_single();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
